// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: dual write ports (write-back and trap controller),
// combinational read with pending-write bypass, and 64-bit mcycle/minstret counters.
module csr_regfile #(
    parameter logic [31:0] HART_ID  = 32'h0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csr_wen_i,
    input  logic [11:0] csr_wr_addr_i,
    input  logic [31:0] csr_wr_data_i,
    input  logic        trap_wen_i,
    input  logic [11:0] trap_wr_addr_i,
    input  logic [31:0] trap_wr_data_i,
    input  logic        retire_i,
    input  logic        timer_irq_i,
    input  logic        ext_irq_i,
    input  logic [11:0] csr_rd_addr_i,
    output logic [31:0] csr_rd_data_o,
    output logic [31:0] mstatus_o,
    output logic [31:0] mie_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MTVAL, ADDR_MCYCLE, ADDR_MCYCLEH,
            ADDR_MINSTRET, ADDR_MINSTRETH: is_writable = 1'b1;
            default:                       is_writable = 1'b0;
        endcase
    endfunction

    // Value that a write of d to address a actually stores (also what the bypass returns).
    function automatic logic [31:0] wr_value(input logic [11:0] a, input logic [31:0] d);
        case (a)
            ADDR_MSTATUS:          wr_value = {19'b0, 2'b11, 3'b0, d[7], 3'b0, d[3], 3'b0};
            ADDR_MIE:              wr_value = d & 32'h0000_0888;
            ADDR_MTVEC, ADDR_MEPC: wr_value = {d[31:2], 2'b00};
            default:               wr_value = d;
        endcase
    endfunction

    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic        timer_q, ext_q;
    logic [63:0] mcycle_q, minstret_q;

    logic        trap_hit, wb_hit;
    logic [31:0] trap_val, wb_val;

    always_comb begin
        trap_hit = trap_wen_i && is_writable(trap_wr_addr_i);
        wb_hit   = csr_wen_i && is_writable(csr_wr_addr_i)
                   && !(trap_hit && (trap_wr_addr_i == csr_wr_addr_i));
        trap_val = wr_value(trap_wr_addr_i, trap_wr_data_i);
        wb_val   = wr_value(csr_wr_addr_i, csr_wr_data_i);
    end

    // Trap-port case follows the write-back case so its assignment wins on a collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (wb_hit) begin
                case (csr_wr_addr_i)
                    ADDR_MSTATUS:  mstatus_q  <= wb_val;
                    ADDR_MIE:      mie_q      <= wb_val;
                    ADDR_MTVEC:    mtvec_q    <= wb_val;
                    ADDR_MSCRATCH: mscratch_q <= wb_val;
                    ADDR_MEPC:     mepc_q     <= wb_val;
                    ADDR_MCAUSE:   mcause_q   <= wb_val;
                    ADDR_MTVAL:    mtval_q    <= wb_val;
                    default: ;
                endcase
            end
            if (trap_hit) begin
                case (trap_wr_addr_i)
                    ADDR_MSTATUS:  mstatus_q  <= trap_val;
                    ADDR_MIE:      mie_q      <= trap_val;
                    ADDR_MTVEC:    mtvec_q    <= trap_val;
                    ADDR_MSCRATCH: mscratch_q <= trap_val;
                    ADDR_MEPC:     mepc_q     <= trap_val;
                    ADDR_MCAUSE:   mcause_q   <= trap_val;
                    ADDR_MTVAL:    mtval_q    <= trap_val;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            timer_q <= timer_irq_i;
            ext_q   <= ext_irq_i;
        end
    end

    logic        cyc_lo_we, cyc_hi_we, ins_lo_we, ins_hi_we;
    logic [31:0] cyc_lo_d, cyc_hi_d, ins_lo_d, ins_hi_d;

    always_comb begin
        cyc_lo_we = 1'b0;
        cyc_hi_we = 1'b0;
        ins_lo_we = 1'b0;
        ins_hi_we = 1'b0;
        cyc_lo_d  = '0;
        cyc_hi_d  = '0;
        ins_lo_d  = '0;
        ins_hi_d  = '0;
        if (wb_hit) begin
            case (csr_wr_addr_i)
                ADDR_MCYCLE:    begin cyc_lo_we = 1'b1; cyc_lo_d = wb_val; end
                ADDR_MCYCLEH:   begin cyc_hi_we = 1'b1; cyc_hi_d = wb_val; end
                ADDR_MINSTRET:  begin ins_lo_we = 1'b1; ins_lo_d = wb_val; end
                ADDR_MINSTRETH: begin ins_hi_we = 1'b1; ins_hi_d = wb_val; end
                default: ;
            endcase
        end
        if (trap_hit) begin
            case (trap_wr_addr_i)
                ADDR_MCYCLE:    begin cyc_lo_we = 1'b1; cyc_lo_d = trap_val; end
                ADDR_MCYCLEH:   begin cyc_hi_we = 1'b1; cyc_hi_d = trap_val; end
                ADDR_MINSTRET:  begin ins_lo_we = 1'b1; ins_lo_d = trap_val; end
                ADDR_MINSTRETH: begin ins_hi_we = 1'b1; ins_hi_d = trap_val; end
                default: ;
            endcase
        end
    end

    logic [32:0] cyc_lo_inc, ins_lo_inc;
    logic [63:0] mcycle_nx, minstret_nx;

    // A low-word write drops the carry; a high-word write discards the low word's carry.
    always_comb begin
        cyc_lo_inc = {1'b0, mcycle_q[31:0]} + 33'd1;
        ins_lo_inc = {1'b0, minstret_q[31:0]} + {32'b0, retire_i};

        mcycle_nx[31:0]  = cyc_lo_we ? cyc_lo_d : cyc_lo_inc[31:0];
        if (cyc_hi_we)
            mcycle_nx[63:32] = cyc_hi_d;
        else if (cyc_lo_we)
            mcycle_nx[63:32] = mcycle_q[63:32];
        else
            mcycle_nx[63:32] = mcycle_q[63:32] + {31'b0, cyc_lo_inc[32]};

        minstret_nx[31:0] = ins_lo_we ? ins_lo_d : ins_lo_inc[31:0];
        if (ins_hi_we)
            minstret_nx[63:32] = ins_hi_d;
        else if (ins_lo_we)
            minstret_nx[63:32] = minstret_q[63:32];
        else
            minstret_nx[63:32] = minstret_q[63:32] + {31'b0, ins_lo_inc[32]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_nx;
            minstret_q <= minstret_nx;
        end
    end

    logic [31:0] rd_base;

    always_comb begin
        rd_base = '0;
        case (csr_rd_addr_i)
            ADDR_MSTATUS:                rd_base = mstatus_q;
            ADDR_MISA:                   rd_base = MISA_VAL;
            ADDR_MIE:                    rd_base = mie_q;
            ADDR_MTVEC:                  rd_base = mtvec_q;
            ADDR_MSCRATCH:               rd_base = mscratch_q;
            ADDR_MEPC:                   rd_base = mepc_q;
            ADDR_MCAUSE:                 rd_base = mcause_q;
            ADDR_MTVAL:                  rd_base = mtval_q;
            ADDR_MIP:                    rd_base = {20'b0, ext_q, 3'b0, timer_q, 7'b0};
            ADDR_MCYCLE, ADDR_CYCLE:     rd_base = mcycle_q[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH:   rd_base = mcycle_q[63:32];
            ADDR_MINSTRET, ADDR_INSTRET: rd_base = minstret_q[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: rd_base = minstret_q[63:32];
            ADDR_MHARTID:                rd_base = HART_ID;
            default:                     rd_base = '0;
        endcase

        if (trap_hit && (trap_wr_addr_i == csr_rd_addr_i))
            csr_rd_data_o = trap_val;
        else if (wb_hit && (csr_wr_addr_i == csr_rd_addr_i))
            csr_rd_data_o = wb_val;
        else
            csr_rd_data_o = rd_base;
    end

    assign mstatus_o = mstatus_q;
    assign mie_o     = mie_q;
    assign mtvec_o   = mtvec_q;
    assign mepc_o    = mepc_q;

endmodule
